// File: rtl/wb_arbiter_master.sv
// Round-robin arbiter that funnels N_CH requesters onto one Wishbone classic master port,
// with HB-size lane steering, alignment checking and a bus timeout.
module wb_arbiter_master #(
  parameter int N_CH           = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       i_CLK,
  input  logic                       i_RSTn,
  input  logic [N_CH-1:0]            i_REQ,
  input  logic [N_CH*ADDR_WIDTH-1:0] i_ADDR,
  input  logic [N_CH*32-1:0]         i_WDATA,
  input  logic [N_CH-1:0]            i_WE,
  input  logic [N_CH*2-1:0]          i_HB,
  output logic [31:0]                o_RDATA,
  output logic [N_CH-1:0]            o_GNT,
  output logic [N_CH-1:0]            o_ERR,
  output logic [ADDR_WIDTH-1:0]      o_WB_ADDR,
  output logic [31:0]                o_WB_DATA,
  input  logic [31:0]                i_WB_DATA,
  output logic                       o_WB_WE,
  output logic [3:0]                 o_WB_SEL,
  output logic                       o_WB_STB,
  output logic                       o_WB_CYC,
  input  logic                       i_WB_ACK,
  input  logic                       i_WB_ERR
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Abort on the BUS cycle whose increment would make the count reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrate and latch payload
  // BUS    | CYC/STB asserted, waiting for ACK/ERR or timeout
  // RESP   | one-cycle GNT/ERR pulse, advance priority pointer
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CH_W-1:0]       r_ptr, w_ptr_nxt, r_ch, w_ch_nxt, w_pick;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [1:0]            r_lo, w_lo_nxt, r_hb, w_hb_nxt, w_hb;
  logic                  r_we, w_we_nxt, w_we, w_found, w_misal;
  logic [31:0]           r_rdata, w_rdata_nxt, w_rd_lane, w_wdata, w_lane_wdata;
  logic [N_CH-1:0]       r_gnt, w_gnt_nxt, r_err, w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_wb_addr, w_wb_addr_nxt, w_addr;
  logic [31:0]           r_wb_data, w_wb_data_nxt;
  logic [3:0]            r_wb_sel, w_wb_sel_nxt, w_sel;
  logic                  r_wb_we, w_wb_we_nxt, r_wb_stb, w_wb_stb_nxt, r_wb_cyc, w_wb_cyc_nxt;

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && i_REQ[(int'(r_ptr) + i) % N_CH]) begin
        w_found = 1'b1;
        w_pick  = CH_W'((int'(r_ptr) + i) % N_CH);
      end
    end
  end

  assign w_addr  = i_ADDR[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = i_WDATA[int'(w_pick)*32 +: 32];
  assign w_we    = i_WE[w_pick];
  assign w_hb    = i_HB[int'(w_pick)*2 +: 2];
  assign w_misal = ((w_hb == 2'b01) && w_addr[0]) || (w_hb[1] && (w_addr[1:0] != 2'b00));

  always_comb begin
    w_sel        = 4'b1111;
    w_lane_wdata = w_wdata;
    if (w_hb == 2'b01) begin
      w_sel        = w_addr[1] ? 4'b1100 : 4'b0011;
      w_lane_wdata = {2{w_wdata[15:0]}};
    end else if (w_hb == 2'b00) begin
      w_sel        = 4'b0001 << w_addr[1:0];
      w_lane_wdata = {4{w_wdata[7:0]}};
    end
  end

  always_comb begin
    w_rd_lane = i_WB_DATA;
    if (r_hb == 2'b01) begin
      w_rd_lane = {16'h0, r_lo[1] ? i_WB_DATA[31:16] : i_WB_DATA[15:0]};
    end else if (r_hb == 2'b00) begin
      w_rd_lane = {24'h0, i_WB_DATA[int'(r_lo)*8 +: 8]};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_ch_nxt      = r_ch;
    w_cnt_nxt     = r_cnt;
    w_lo_nxt      = r_lo;
    w_hb_nxt      = r_hb;
    w_we_nxt      = r_we;
    w_rdata_nxt   = r_rdata;
    w_gnt_nxt     = '0;
    w_err_nxt     = '0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;
    w_wb_sel_nxt  = r_wb_sel;
    w_wb_we_nxt   = r_wb_we;
    w_wb_stb_nxt  = r_wb_stb;
    w_wb_cyc_nxt  = r_wb_cyc;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ch_nxt = w_pick;
          w_lo_nxt = w_addr[1:0];
          w_hb_nxt = w_hb;
          w_we_nxt = w_we;
          if (w_misal) begin
            w_err_nxt[w_pick] = 1'b1;
            w_state_nxt       = S_RESP;
          end else begin
            w_wb_addr_nxt = {w_addr[ADDR_WIDTH-1:2], 2'b00};
            w_wb_data_nxt = w_lane_wdata;
            w_wb_sel_nxt  = w_sel;
            w_wb_we_nxt   = w_we;
            w_wb_stb_nxt  = 1'b1;
            w_wb_cyc_nxt  = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_BUS;
          end
        end
      end
      S_BUS: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (i_WB_ERR) begin
          w_wb_stb_nxt    = 1'b0;
          w_wb_cyc_nxt    = 1'b0;
          w_err_nxt[r_ch] = 1'b1;
          w_state_nxt     = S_RESP;
        end else if (i_WB_ACK) begin
          w_wb_stb_nxt    = 1'b0;
          w_wb_cyc_nxt    = 1'b0;
          w_gnt_nxt[r_ch] = 1'b1;
          w_rdata_nxt     = r_we ? 32'h0 : w_rd_lane;
          w_state_nxt     = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
          w_wb_stb_nxt    = 1'b0;
          w_wb_cyc_nxt    = 1'b0;
          w_err_nxt[r_ch] = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        w_ptr_nxt   = (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + CH_W'(1);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_hb      <= '0;
      r_we      <= 1'b0;
      r_rdata   <= '0;
      r_gnt     <= '0;
      r_err     <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_sel  <= '0;
      r_wb_we   <= 1'b0;
      r_wb_stb  <= 1'b0;
      r_wb_cyc  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_ch      <= w_ch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lo      <= w_lo_nxt;
      r_hb      <= w_hb_nxt;
      r_we      <= w_we_nxt;
      r_rdata   <= w_rdata_nxt;
      r_gnt     <= w_gnt_nxt;
      r_err     <= w_err_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_wb_sel  <= w_wb_sel_nxt;
      r_wb_we   <= w_wb_we_nxt;
      r_wb_stb  <= w_wb_stb_nxt;
      r_wb_cyc  <= w_wb_cyc_nxt;
    end
  end

  assign o_RDATA   = r_rdata;
  assign o_GNT     = r_gnt;
  assign o_ERR     = r_err;
  assign o_WB_ADDR = r_wb_addr;
  assign o_WB_DATA = r_wb_data;
  assign o_WB_SEL  = r_wb_sel;
  assign o_WB_WE   = r_wb_we;
  assign o_WB_STB  = r_wb_stb;
  assign o_WB_CYC  = r_wb_cyc;

endmodule

// File: doc/wb_arbiter_master.md
Name: wb_arbiter_master

Overview:
- Parametrised successor to the core's single-LSU Wishbone master.
- Arbitrates N_CH requester channels (e.g. instruction fetch, LSU, debug/DMA) onto one Wishbone classic master port using round-robin priority.
- Generates byte selects from the core's HB size code, checks alignment, applies a bus timeout, and returns a per-channel GNT or ERR pulse.
- Sits between the core's requesters and the system Wishbone interconnect.

Parameters:
- N_CH, 2, number of requester channels (1..8).
- ADDR_WIDTH, 32, address width in bits.
- TIMEOUT_CYCLES, 255, maximum cycles in BUS without ACK/ERR before aborting. 0 disables the timeout.
- DATA_WIDTH is fixed at 32 and is not a parameter.

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_REQ  in  N_CH  per-channel request level
- i_ADDR  in  N_CH*ADDR_WIDTH  per-channel byte address; channel k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_WDATA  in  N_CH*32  per-channel write data, right-justified
- i_WE  in  N_CH  per-channel write enable (1 = write)
- i_HB  in  N_CH*2  per-channel size code: 00 = byte, 01 = half, 1x = word
- o_RDATA  out  32  read data, shared by all channels, valid only with a GNT pulse
- o_GNT  out  N_CH  one-cycle completion pulse, one-hot
- o_ERR  out  N_CH  one-cycle error pulse, one-hot
- o_WB_ADDR  out  ADDR_WIDTH  Wishbone address, word-aligned (bits [1:0] = 0)
- o_WB_DATA  out  32  Wishbone write data, lane-replicated
- i_WB_DATA  in  32  Wishbone read data
- o_WB_WE  out  1  Wishbone write enable
- o_WB_SEL  out  4  Wishbone byte select
- o_WB_STB  out  1  Wishbone strobe
- o_WB_CYC  out  1  Wishbone cycle
- i_WB_ACK  in  1  Wishbone acknowledge
- i_WB_ERR  in  1  Wishbone error

Behaviour:
- Reset (asynchronous, i_RSTn = 0):
  - All outputs go to 0: o_RDATA, o_GNT, o_ERR, every o_WB_* output.
  - FSM goes to IDLE, priority pointer to 0, timeout counter to 0.
  - Reset asserted mid-transfer drops CYC/STB immediately; no GNT or ERR is issued for that transfer.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - If any i_REQ is high, select the first requesting channel at or after the priority pointer (wrapping) and latch that channel's ADDR, WDATA, WE and HB.
  - Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with an error for that channel; no bus cycle is started.
  - Otherwise go to BUS and assert CYC = STB = 1 on the next cycle.
- Lane generation:
  - SEL: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - o_WB_DATA: byte replicated to all four lanes, half replicated to both halves, word unchanged.
  - o_WB_ADDR = latched address with bits [1:0] cleared.
- BUS:
  - CYC, STB, ADDR, DATA, WE and SEL are held stable.
  - The timeout counter increments each cycle in BUS.
  - i_WB_ACK: capture the read lane, right-justify and zero-extend it into o_RDATA (writes: o_RDATA = 0). Drop CYC/STB and go to RESP with a GNT.
  - i_WB_ERR, or ACK and ERR together: ERR wins. Drop CYC/STB and go to RESP with an error.
  - Counter == TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0): drop CYC/STB and go to RESP with an error; a late ACK is ignored.
- RESP:
  - Exactly one of o_GNT[k] or o_ERR[k] is high for exactly one cycle.
  - Priority pointer becomes (k+1) mod N_CH.
  - Return to IDLE; a new request is sampled in the following IDLE cycle.
- Latency: for REQ sampled in IDLE at cycle 0, CYC/STB is high from cycle 1. An ACK in cycle a gives the GNT in cycle a+1. Zero-wait slave: GNT at cycle 2. Minimum spacing between grants is 3 cycles.
- Requester rule: hold REQ and all payload signals stable until GNT or ERR. Deasserting REQ in BUS does not abort the transfer; the pulse is still issued.
- N_CH = 1: arbitration degenerates to a pass-through, with identical timing.

Test Plan:
- Ch0 word read at 0x100, slave ACKs in cycle 1 with 0xDEADBEEF -> WB_ADDR = 0x100, SEL = 1111, WE = 0; o_GNT = 01 in cycle 2; o_RDATA = 0xDEADBEEF.
- Ch1 byte write at 0x203, data 0xA5 -> WB_ADDR = 0x200, SEL = 1000, WB_DATA = 0xA5A5A5A5; o_GNT = 10. Repeat as a half read at 0x202 with bus data 0x1234ABCD -> o_RDATA = 0x00001234.
- Both channels hold REQ for 4 transfers from reset -> grant order ch0, ch1, ch0, ch1; no GNT pulses in consecutive cycles.
- Ch0 half access at 0x101 -> o_ERR = 01 in cycle 1, CYC never asserted; ch1 is served next.
- TIMEOUT_CYCLES = 4, slave never responds -> CYC high for exactly 4 cycles, then o_ERR pulse. An ACK arriving afterwards produces no GNT.
- i_RSTn pulled low while in BUS -> CYC/STB low immediately, no GNT/ERR. After release, ch0 has priority.
